// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the raster timing generator:
//   - vga_axis_t : packed bundle of the four region widths of one axis
//                  (front porch, sync, back porch, active).
//   - Standard mode tables (horizontal in clocks, vertical in lines):
//       800x600  @ 40 MHz (default of vga_timing_gen)
//       640x480  @ 25 MHz
//       1024x768 @ 65 MHz
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
        logic [15:0] active;
    } vga_axis_t;

    localparam vga_axis_t MODE_800X600_H  = '{fp: 16'd40, sync: 16'd128, bp: 16'd88,  active: 16'd800};
    localparam vga_axis_t MODE_800X600_V  = '{fp: 16'd1,  sync: 16'd4,   bp: 16'd23,  active: 16'd600};

    localparam vga_axis_t MODE_640X480_H  = '{fp: 16'd16, sync: 16'd96,  bp: 16'd48,  active: 16'd640};
    localparam vga_axis_t MODE_640X480_V  = '{fp: 16'd10, sync: 16'd2,   bp: 16'd33,  active: 16'd480};

    localparam vga_axis_t MODE_1024X768_H = '{fp: 16'd24, sync: 16'd136, bp: 16'd160, active: 16'd1024};
    localparam vga_axis_t MODE_1024X768_V = '{fp: 16'd3,  sync: 16'd6,   bp: 16'd29,  active: 16'd768};

    // Total period of one axis (sum of its four regions).
    function automatic int axis_total(input vga_axis_t a);
        return int'(a.fp) + int'(a.sync) + int'(a.bp) + int'(a.active);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 with regions in
// the order FP, SYNC, BP, ACTIVE (count 0 = first front-porch unit).
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   clr_i         : load the counter to 0 at the next edge (sync forced idle)
//   adv_i         : advance the counter at the next edge
//   cnt_o         : current (registered) count
//   next_cnt_o    : count that will be loaded at the next edge
//   wrap_o        : current count is the last of the period
//   sync_o        : registered sync at POL, aligned with cnt_o
//   active_o      : next_cnt_o lies in the active region (0 while clr_i)
//   offset_o      : next_cnt_o minus the active-region start
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int FP     = 1,
    parameter int SYNC   = 1,
    parameter int BP     = 1,
    parameter int ACTIVE = 1,
    parameter bit POL    = 1'b1,
    parameter int CW     = $clog2(FP + SYNC + BP + ACTIVE)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [CW-1:0] cnt_o,
    output logic [CW-1:0] next_cnt_o,
    output logic          wrap_o,
    output logic          sync_o,
    output logic          active_o,
    output logic [CW-1:0] offset_o
);

    localparam int TOTAL = FP + SYNC + BP + ACTIVE;
    localparam int START = FP + SYNC + BP;

    localparam logic [CW-1:0] LAST_C    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_LO_C = CW'(FP);
    localparam logic [CW-1:0] SYNC_HI_C = CW'(FP + SYNC);
    localparam logic [CW-1:0] START_C   = CW'(START);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync_q, sync_d;
    logic          in_sync_s;

    assign wrap_o = (cnt_q == LAST_C);

    // Next-count selection: clear wins over advance, advance wraps at the end.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            if (wrap_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sync decode from the next count so the registered sync lines up with cnt_o.
    always_comb begin
        in_sync_s = 1'b0;
        if (!clr_i && (cnt_d >= SYNC_LO_C) && (cnt_d < SYNC_HI_C)) begin
            in_sync_s = 1'b1;
        end else begin
            in_sync_s = 1'b0;
        end
        sync_d = in_sync_s ? POL : ~POL;
    end

    // Count and sync registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sync_q <= ~POL;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign next_cnt_o = cnt_d;
    assign sync_o     = sync_q;
    assign active_o   = !clr_i && (cnt_d >= START_C);
    assign offset_o   = cnt_d - START_C;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator (pixel clock domain).
// Ports:
//   clk, reset_n   : pixel clock, asynchronous active-low reset
//   en             : timing enable; low clears the raster to 0/0
//   scale_x/_y     : pixel / line replication 2^scale (latched at frame start)
//   line_cmp       : raster-compare line (raw vcnt)
//   hcnt, vcnt     : raw counters
//   hs, vs         : syncs at HS_POL / VS_POL
//   de, de_early   : display enable and its LEAD-clock early copy
//   x, y           : scaled active column / row
//   line_stb, frame_stb, cmp_irq : single-clock strobes at line start
// All outputs are registered from the next-state counts, so they align with
// hcnt/vcnt in the same cycle.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_FP     = int'(MODE_800X600_H.fp),
    parameter int H_SYNC   = int'(MODE_800X600_H.sync),
    parameter int H_BP     = int'(MODE_800X600_H.bp),
    parameter int H_ACTIVE = int'(MODE_800X600_H.active),
    parameter int V_FP     = int'(MODE_800X600_V.fp),
    parameter int V_SYNC   = int'(MODE_800X600_V.sync),
    parameter int V_BP     = int'(MODE_800X600_V.bp),
    parameter int V_ACTIVE = int'(MODE_800X600_V.active),
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int LEAD     = 3,
    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE,
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE,
    localparam int H_START = H_FP + H_SYNC + H_BP,
    localparam int V_START = V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL),
    localparam int XW      = $clog2(H_ACTIVE),
    localparam int YW      = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [1:0]    scale_x,
    input  logic [1:0]    scale_y,
    input  logic [VW-1:0] line_cmp,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          de_early,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_stb,
    output logic          frame_stb,
    output logic          cmp_irq
);

    if (LEAD < 0 || LEAD > H_BP ||
        H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 || H_ACTIVE <= 0 ||
        V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 || V_ACTIVE <= 0) begin : g_param_err
        $error("vga_timing_gen: LEAD must be 0..H_BP and every region width must be non-zero");
    end

    localparam logic [HW-1:0] DEE_LO_C = HW'(H_START - LEAD);
    // One extra bit: with LEAD=0 the upper bound equals H_TOTAL.
    localparam logic [HW:0]   DEE_HI_C = (HW+1)'(H_TOTAL - LEAD);

    logic          clr_s;
    logic          run_q;
    logic [HW-1:0] h_cnt_s, h_next_s, h_off_s;
    logic [VW-1:0] v_cnt_s, v_next_s, v_off_s;
    logic          h_wrap_s, v_wrap_s, h_act_s, v_act_s;
    logic          unused_v_wrap_s;

    logic [1:0]    sx_q, sx_d, sy_q, sy_d;
    logic          de_q, de_d, de_early_q, de_early_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          line_q, line_d, frame_q, frame_d, cmp_q, cmp_d;

    assign clr_s           = ~en;
    assign unused_v_wrap_s = v_wrap_s;

    vga_axis_counter #(
        .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .POL(HS_POL), .CW(HW)
    ) u_h_axis (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (clr_s),
        .adv_i      (run_q),
        .cnt_o      (h_cnt_s),
        .next_cnt_o (h_next_s),
        .wrap_o     (h_wrap_s),
        .sync_o     (hs),
        .active_o   (h_act_s),
        .offset_o   (h_off_s)
    );

    vga_axis_counter #(
        .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .POL(VS_POL), .CW(VW)
    ) u_v_axis (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (clr_s),
        .adv_i      (run_q & h_wrap_s),
        .cnt_o      (v_cnt_s),
        .next_cnt_o (v_next_s),
        .wrap_o     (v_wrap_s),
        .sync_o     (vs),
        .active_o   (v_act_s),
        .offset_o   (v_off_s)
    );

    // Next-state decode of enables, strobes, scaling and coordinates.
    always_comb begin
        line_d     = !clr_s && (h_next_s == '0);
        frame_d    = line_d && (v_next_s == '0);
        cmp_d      = line_d && (v_next_s == line_cmp);
        de_d       = h_act_s && v_act_s;
        de_early_d = v_act_s && (h_next_s >= DEE_LO_C) && ({1'b0, h_next_s} < DEE_HI_C);

        // Scale factors only change at a frame boundary.
        if (clr_s) begin
            sx_d = 2'd0;
            sy_d = 2'd0;
        end else if (frame_d) begin
            sx_d = scale_x;
            sy_d = scale_y;
        end else begin
            sx_d = sx_q;
            sy_d = sy_q;
        end

        if (de_d) begin
            x_d = XW'(h_off_s >> sx_q);
        end else begin
            x_d = '0;
        end

        // y keeps the last row through blanking; cleared at frame start.
        if (clr_s || frame_d) begin
            y_d = '0;
        end else if (v_act_s) begin
            y_d = YW'(v_off_s >> sy_q);
        end else begin
            y_d = y_q;
        end
    end

    // Run flag: first enabled edge presents 0/0 instead of advancing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= en;
        end
    end

    // Output and scale registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q       <= 2'd0;
            sy_q       <= 2'd0;
            de_q       <= 1'b0;
            de_early_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
            cmp_q      <= 1'b0;
        end else begin
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            de_q       <= de_d;
            de_early_q <= de_early_d;
            x_q        <= x_d;
            y_q        <= y_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            cmp_q      <= cmp_d;
        end
    end

    assign hcnt      = h_cnt_s;
    assign vcnt      = v_cnt_s;
    assign de        = de_q;
    assign de_early  = de_early_q;
    assign x         = x_q;
    assign y         = y_q;
    assign line_stb  = line_q;
    assign frame_stb = frame_q;
    assign cmp_irq   = cmp_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Small-mode bench (H 2/3/4/8, V 1/2/1/4, LEAD=2). Two instances share inputs:
// one with active-high syncs, one with active-low syncs. The reference model
// tracks elapsed enabled clocks t and derives hcnt = t mod 17,
// vcnt = (t div 17) mod 8, then every output from the region rules.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int H_FP = 2, H_SYNC = 3, H_BP = 4, H_ACT = 8;
    localparam int V_FP = 1, V_SYNC = 2, V_BP = 1, V_ACT = 4;
    localparam int LEAD = 2;
    localparam int H_TOT = H_FP + H_SYNC + H_BP + H_ACT;   // 17
    localparam int V_TOT = V_FP + V_SYNC + V_BP + V_ACT;   // 8
    localparam int H_ST  = H_FP + H_SYNC + H_BP;           // 9
    localparam int V_ST  = V_FP + V_SYNC + V_BP;           // 4

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       en      = 1'b0;
    logic [1:0] scale_x = 2'd0;
    logic [1:0] scale_y = 2'd0;
    logic [2:0] line_cmp = 3'd5;

    logic [4:0] hcnt, hcnt_n;
    logic [2:0] vcnt, vcnt_n;
    logic       hs, vs, de, de_early, line_stb, frame_stb, cmp_irq;
    logic       hs_n, vs_n, de_n, de_early_n, line_stb_n, frame_stb_n, cmp_irq_n;
    logic [2:0] x, x_n;
    logic [1:0] y, y_n;

    vga_timing_gen #(
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACT),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACT),
        .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(LEAD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .scale_x(scale_x), .scale_y(scale_y),
        .line_cmp(line_cmp), .hcnt(hcnt), .vcnt(vcnt), .hs(hs), .vs(vs), .de(de),
        .de_early(de_early), .x(x), .y(y), .line_stb(line_stb), .frame_stb(frame_stb),
        .cmp_irq(cmp_irq)
    );

    vga_timing_gen #(
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACT),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACT),
        .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(LEAD)
    ) dut_n (
        .clk(clk), .reset_n(reset_n), .en(en), .scale_x(scale_x), .scale_y(scale_y),
        .line_cmp(line_cmp), .hcnt(hcnt_n), .vcnt(vcnt_n), .hs(hs_n), .vs(vs_n), .de(de_n),
        .de_early(de_early_n), .x(x_n), .y(y_n), .line_stb(line_stb_n),
        .frame_stb(frame_stb_n), .cmp_irq(cmp_irq_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_frame = -1;

    // reference model state
    bit m_run = 1'b0;
    int m_t   = 0;
    int m_sx  = 0;
    int m_sy  = 0;
    int m_lc  = 5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_sx  = 0;
        m_sy  = 0;
    endtask

    // Advance the model on a clock edge using the inputs the DUT sampled.
    task automatic model_update();
        if (!reset_n || !en) begin
            model_reset();
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
            end
            if (m_t % (H_TOT * V_TOT) == 0) begin
                m_sx = int'(scale_x);
                m_sy = int'(scale_y);
            end
        end
        m_lc = int'(line_cmp);
    endtask

    task automatic check_all();
        int h, v, x_e, y_e;
        bit hs_e, vs_e, de_e, dee_e, line_e, frame_e, cmp_e;
        h       = m_run ? (m_t % H_TOT) : 0;
        v       = m_run ? ((m_t / H_TOT) % V_TOT) : 0;
        hs_e    = m_run && (h >= H_FP) && (h < H_FP + H_SYNC);
        vs_e    = m_run && (v >= V_FP) && (v < V_FP + V_SYNC);
        de_e    = m_run && (h >= H_ST) && (v >= V_ST);
        dee_e   = m_run && (v >= V_ST) && (h >= H_ST - LEAD) && (h < H_TOT - LEAD);
        x_e     = de_e ? ((h - H_ST) >> m_sx) : 0;
        y_e     = (m_run && v >= V_ST) ? ((v - V_ST) >> m_sy) : 0;
        line_e  = m_run && (h == 0);
        frame_e = line_e && (v == 0);
        cmp_e   = line_e && (v == m_lc);

        chk("hcnt",      32'(hcnt),      32'(h));
        chk("vcnt",      32'(vcnt),      32'(v));
        chk("hs",        32'(hs),        32'(hs_e));
        chk("vs",        32'(vs),        32'(vs_e));
        chk("hs_lowpol", 32'(hs_n),      32'(!hs_e));
        chk("vs_lowpol", 32'(vs_n),      32'(!vs_e));
        chk("de",        32'(de),        32'(de_e));
        chk("de_early",  32'(de_early),  32'(dee_e));
        chk("x",         32'(x),         32'(x_e));
        chk("y",         32'(y),         32'(y_e));
        chk("line_stb",  32'(line_stb),  32'(line_e));
        chk("frame_stb", 32'(frame_stb), 32'(frame_e));
        chk("cmp_irq",   32'(cmp_irq),   32'(cmp_e));

        if (!m_run) begin
            last_frame = -1;
        end
        if (frame_stb === 1'b1) begin
            if (last_frame >= 0) begin
                chk("frame_period", 32'(cyc - last_frame), 32'(H_TOT * V_TOT));
            end
            last_frame = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    initial begin : main
        bit found;

        // Asynchronous reset from time 0, checked before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_hs_lowpol_high", 32'(hs_n), 32'd1);
        chk("rst_vs_lowpol_high", 32'(vs_n), 32'd1);

        repeat (2) tick();
        reset_n = 1'b1;
        tick();                       // enabled low: idle
        en = 1'b1;
        tick();
        chk("first_frame_stb", 32'(frame_stb), 32'd1);

        // Run part of a frame, then change scale mid-frame.
        repeat (60) tick();
        scale_x = 2'd1;
        scale_y = 2'd1;
        repeat (2 * H_TOT * V_TOT) tick();

        // Raster compare on line 5 for a full frame, counting pulses.
        begin
            int n_irq;
            n_irq = 0;
            line_cmp = 3'd5;
            for (int i = 0; i < H_TOT * V_TOT; i++) begin
                tick();
                if (cmp_irq === 1'b1) n_irq++;
            end
            chk("cmp_irq_per_frame", 32'(n_irq), 32'd1);
        end

        // Asynchronous reset mid-line at hcnt=12, vcnt=5.
        found = 1'b0;
        for (int i = 0; i < 2 * H_TOT * V_TOT && !found; i++) begin
            tick();
            if (m_run && (m_t % H_TOT == 12) && ((m_t / H_TOT) % V_TOT == 5)) found = 1'b1;
        end
        chk("found_12_5", 32'(found), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("restart_after_reset", 32'(frame_stb), 32'd1);

        // en low for three clocks, then restart at 0/0.
        repeat (50) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        tick();
        chk("restart_after_en", 32'(frame_stb), 32'd1);

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 99) == 0) scale_x = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) scale_y = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) line_cmp = 3'($urandom_range(0, 7));
            en = ($urandom_range(0, 399) != 0) ? 1'b1 : 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
